// File: rtl/draw_sprite.sv
// Sprite drawer: streams an 8x8 sprite frame from a synchronous ROM onto the VGA plot bus,
// skipping transparent and off-screen pixels. Optional macro SPRITE_MIRROR_EN adds horizontal flip.
module draw_sprite #(
    parameter int          W_LOG2      = 3,
    parameter int          H_LOG2      = 3,
    parameter int          FRAME_BITS  = 2,
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120,
    parameter logic [2:0]  TRANSPARENT = 3'b101
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic                                 enable,
    input  logic [7:0]                           pos_x,
    input  logic [6:0]                           pos_y,
    input  logic [FRAME_BITS-1:0]                frame,
`ifdef SPRITE_MIRROR_EN
    input  logic                                 mirror,
`endif
    output logic [FRAME_BITS+H_LOG2+W_LOG2-1:0]  rom_addr,
    input  logic [2:0]                           rom_data,
    output logic [7:0]                           x,
    output logic [6:0]                           y,
    output logic [2:0]                           color,
    output logic                                 plot,
    output logic                                 done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FLUSH, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             pos_x_q, pos_x_d;
    logic [6:0]             pos_y_q, pos_y_d;
    logic [FRAME_BITS-1:0]  frame_q, frame_d;
    logic [W_LOG2-1:0]      col_q, col_d;
    logic [H_LOG2-1:0]      row_q, row_d;
    logic                   flush_q, flush_d;
    logic                   vld_p1_q, vld_p1_d;
    logic [8:0]             xs_p1_q, xs_p1_d;
    logic [7:0]             ys_p1_q, ys_p1_d;
    logic [7:0]             x_q, x_d;
    logic [6:0]             y_q, y_d;
    logic [2:0]             color_q, color_d;
    logic                   plot_q, plot_d;
    logic [W_LOG2-1:0]      col_rom;

    function automatic logic on_screen(input logic [8:0] xs, input logic [7:0] ys);
        return (xs < 9'(SCREEN_W)) && (ys < 8'(SCREEN_H));
    endfunction

`ifdef SPRITE_MIRROR_EN
    logic mirror_q, mirror_d;
    assign col_rom = mirror_q ? ~col_q : col_q;
`else
    assign col_rom = col_q;
`endif

    assign rom_addr = {frame_q, row_q, col_rom};
    assign x        = x_q;
    assign y        = y_q;
    assign color    = color_q;
    assign plot     = plot_q;
    assign done     = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        frame_d  = frame_q;
        col_d    = col_q;
        row_d    = row_q;
        flush_d  = flush_q;
        vld_p1_d = 1'b0;
`ifdef SPRITE_MIRROR_EN
        mirror_d = mirror_q;
`endif
        // Screen coordinates always use the unreversed column, one bit wider to detect overflow.
        xs_p1_d  = {1'b0, pos_x_q} + {{(9 - W_LOG2){1'b0}}, col_q};
        ys_p1_d  = {1'b0, pos_y_q} + {{(8 - H_LOG2){1'b0}}, row_q};
        plot_d   = vld_p1_q && (rom_data != TRANSPARENT) && on_screen(xs_p1_q, ys_p1_q);

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_DRAW;
                    pos_x_d = pos_x;
                    pos_y_d = pos_y;
                    frame_d = frame;
                    col_d   = '0;
                    row_d   = '0;
                    flush_d = 1'b0;
`ifdef SPRITE_MIRROR_EN
                    mirror_d = mirror;
`endif
                end
            end
            S_DRAW: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    plot_d  = 1'b0;
                end else begin
                    vld_p1_d = 1'b1;
                    col_d    = col_q + 1'b1;
                    if (col_q == {W_LOG2{1'b1}}) begin
                        row_d = row_q + 1'b1;
                        if (row_q == {H_LOG2{1'b1}}) begin
                            state_d = S_FLUSH;
                            flush_d = 1'b0;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    plot_d  = 1'b0;
                end else if (flush_q) begin
                    state_d = S_DONE;
                end else begin
                    flush_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        if (plot_d) begin
            x_d     = xs_p1_q[7:0];
            y_d     = ys_p1_q[6:0];
            color_d = rom_data;
        end
    end

    // Stage 1 registers the address slot alongside the ROM; stage 2 captures rom_data.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            frame_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            flush_q  <= 1'b0;
            vld_p1_q <= 1'b0;
            xs_p1_q  <= '0;
            ys_p1_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            plot_q   <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            mirror_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            frame_q  <= frame_d;
            col_q    <= col_d;
            row_q    <= row_d;
            flush_q  <= flush_d;
            vld_p1_q <= vld_p1_d;
            xs_p1_q  <= xs_p1_d;
            ys_p1_q  <= ys_p1_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            plot_q   <= plot_d;
`ifdef SPRITE_MIRROR_EN
            mirror_q <= mirror_d;
`endif
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// Scoreboard bench for draw_sprite: a pixel-level reference model fills an expected-plot queue,
// a negedge monitor pops and compares every plot the DUT emits.
module tb_draw_sprite;

    logic       clock = 1'b0;
    logic       resetn;
    logic       enable;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic [1:0] frame;
    logic       mirror;
    logic [7:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot;
    logic       done;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t       exp_q[$];
    logic [2:0] rom_mem [0:255];
    int         checks = 0;
    int         errors = 0;
    int         plot_cnt = 0;

    draw_sprite dut (
        .clock    (clock),
        .resetn   (resetn),
        .enable   (enable),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .frame    (frame),
`ifdef SPRITE_MIRROR_EN
        .mirror   (mirror),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .x        (x),
        .y        (y),
        .color    (color),
        .plot     (plot),
        .done     (done)
    );

    always #5 clock = ~clock;

    // Synchronous ROM with one cycle of latency.
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    always @(negedge clock) begin
        if (resetn === 1'b1 && plot === 1'b1) begin
            pix_t e;
            plot_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d, none expected", x, y, color);
            end else begin
                e = exp_q.pop_front();
                if (x !== e.x || y !== e.y || color !== e.c) begin
                    errors++;
                    $display("FAIL plot_xyc got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                             x, y, color, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Pixel k = row*8+col; colour from the (possibly mirrored) ROM column, position from the real column.
    task automatic gen_expected(input int px, input int py, input int fr, input int maxk);
        for (int k = 0; k <= maxk; k++) begin
            int r, c, rc, xs, ys;
            logic [2:0] col;
            pix_t p;
            r   = k / 8;
            c   = k % 8;
            rc  = mirror ? 7 - c : c;
            col = rom_mem[fr * 64 + r * 8 + rc];
            xs  = px + c;
            ys  = py + r;
            if (col != 3'b101 && xs < 160 && ys < 120) begin
                p.x = 8'(xs);
                p.y = 7'(ys);
                p.c = col;
                exp_q.push_back(p);
            end
        end
    endtask

    function automatic int exp_addr(input int fr, input int n);
        int c;
        c = mirror ? 7 - (n % 8) : n % 8;
        return fr * 64 + (n / 8) * 8 + c;
    endfunction

    task automatic fill_solid(input logic [2:0] c);
        for (int i = 0; i < 256; i++) rom_mem[i] = c;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    endtask

    // Drives one full draw from IDLE; caller is positioned just after a rising edge.
    task automatic run_draw(input int px, input int py, input int fr, input int want_plots);
        int n;
        gen_expected(px, py, fr, 63);
        plot_cnt = 0;
        pos_x  = 8'(px);
        pos_y  = 7'(py);
        frame  = 2'(fr);
        enable = 1'b1;
        @(posedge clock);
        #1;
        pos_x = 8'($urandom);
        pos_y = 7'($urandom);
        frame = 2'($urandom);
        n = 0;
        check("rom_addr_first", int'(rom_addr), exp_addr(fr, 0));
        while (n < 200 && done !== 1'b1) begin
            @(posedge clock);
            #1;
            n++;
            if (n < 64 && int'(rom_addr) != exp_addr(fr, n)) begin
                check("rom_addr_seq", int'(rom_addr), exp_addr(fr, n));
            end
        end
        check("done_edge", n, 66);
        check("queue_drained", exp_q.size(), 0);
        if (want_plots >= 0) check("plot_count", plot_cnt, want_plots);
        exp_q.delete();
        @(posedge clock);
        check("done_held", int'(done), 1);
        #1;
        enable = 1'b0;
        @(posedge clock);
        #1;
        check("done_clear", int'(done), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        enable = 1'b0;
        pos_x  = '0;
        pos_y  = '0;
        frame  = '0;
        mirror = 1'b0;
        fill_solid(3'b010);
        repeat (3) @(posedge clock);
        #1;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_color", int'(color), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_done", int'(done), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Solid sprite at (10,20), frame 1.
        run_draw(10, 20, 1, 64);

        // Checkerboard with transparent squares on frame 0.
        for (int i = 0; i < 64; i++) rom_mem[i] = (((i / 8) + (i % 8)) % 2 == 1) ? 3'b101 : 3'b001;
        run_draw(30, 40, 0, 32);

        // Bottom-right corner clip.
        fill_solid(3'b010);
        run_draw(156, 116, 2, 16);

        // Abort after 20 DRAW edges: pixels 0..18 reach the bus before the abort edge.
        begin
            fill_random();
            gen_expected(50, 60, 3, 18);
            pos_x  = 8'd50;
            pos_y  = 7'd60;
            frame  = 2'd3;
            enable = 1'b1;
            @(posedge clock);
            repeat (20) @(posedge clock);
            #1;
            enable = 1'b0;
            @(posedge clock);
            #1;
            check("abort_done", int'(done), 0);
            check("abort_plot", int'(plot), 0);
            repeat (80) @(posedge clock);
            #1;
            check("abort_done_late", int'(done), 0);
            check("abort_queue", exp_q.size(), 0);
            exp_q.delete();
            run_draw(5, 6, 3, -1);
        end

        // Asynchronous reset mid-draw, after pixel 28 has been shown.
        begin
            fill_solid(3'b110);
            gen_expected(70, 80, 1, 28);
            pos_x  = 8'd70;
            pos_y  = 7'd80;
            frame  = 2'd1;
            enable = 1'b1;
            @(posedge clock);
            repeat (30) @(posedge clock);
            #6;
            resetn = 1'b0;
            #1;
            check("arst_x", int'(x), 0);
            check("arst_y", int'(y), 0);
            check("arst_color", int'(color), 0);
            check("arst_plot", int'(plot), 0);
            check("arst_done", int'(done), 0);
            check("arst_rom_addr", int'(rom_addr), 0);
            check("arst_queue", exp_q.size(), 0);
            exp_q.delete();
            repeat (2) @(posedge clock);
            #1;
            resetn = 1'b1;
            run_draw(70, 80, 1, 64);
        end

`ifdef SPRITE_MIRROR_EN
        // Mirrored: ROM row 0 holds colours 0..7 by column.
        fill_random();
        for (int c = 0; c < 8; c++) rom_mem[c] = 3'(c);
        mirror = 1'b1;
        run_draw(0, 0, 0, -1);
        mirror = 1'b0;
`endif

        // Randomized draws, including positions that clip on either edge.
        for (int t = 0; t < 6; t++) begin
            fill_random();
`ifdef SPRITE_MIRROR_EN
            mirror = 1'($urandom);
`endif
            run_draw($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 3), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
